// File: rtl/fp_pkg.sv
// Shared widths and state encoding for the lab's compact floating-point format
// (sign, 3-bit exponent, 4-bit significand) and its 12-bit two's-complement form.
package fp_pkg;

  localparam int FP_D_W   = 12;
  localparam int FP_E_W   = 3;
  localparam int FP_F_W   = 4;
  localparam int FP_MAG_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SIGN  = 2'd2,
    DONE  = 2'd3
  } fp_state_e;

endpackage

// File: rtl/sm_to_tc.sv
// Sign-magnitude to two's-complement conversion; the magnitude is one bit narrower
// than the result, so the conversion can never overflow and negative zero maps to zero.
module sm_to_tc
  import fp_pkg::*;
(
  input  logic                sign,
  input  logic [FP_MAG_W-1:0] mag,
  output logic [FP_D_W-1:0]   tc
);

  logic [FP_D_W-1:0] mag_ext;

  assign mag_ext = {1'b0, mag};

  always_comb begin
    tc = mag_ext;
    if (sign) begin
      tc = ~mag_ext + {{(FP_D_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fp_to_tc_decoder.sv
// Decodes one compact floating-point word at a time into a 12-bit two's-complement
// integer using a one-bit-per-cycle left shifter, then holds the result until taken.
module fp_to_tc_decoder
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              S,
  input  logic [FP_E_W-1:0] E,
  input  logic [FP_F_W-1:0] F,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_D_W-1:0] D,
  output logic              busy
);

  fp_state_e           state_q, state_d;
  logic [FP_MAG_W-1:0] mag_q, mag_d;
  logic [FP_E_W-1:0]   cnt_q, cnt_d;
  logic                s_q, s_d;
  logic [FP_D_W-1:0]   d_q, d_d;
  logic [FP_D_W-1:0]   tc;

  sm_to_tc u_sm_to_tc (
    .sign (s_q),
    .mag  (mag_q),
    .tc   (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      d_q     <= d_d;
    end
  end

  // The exponent counts remaining shifts; the SHIFT cycle that sees zero is the hand-off to SIGN.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = S;
          cnt_d   = E;
          mag_d   = {{(FP_MAG_W-FP_F_W){1'b0}}, F};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = SIGN;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - {{(FP_E_W-1){1'b0}}, 1'b1};
        end
      end
      SIGN: begin
        d_d     = tc;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign D = d_q;

endmodule

// File: tb/tb_fp_to_tc_decoder.sv
// Scoreboard bench for fp_to_tc_decoder: accepted words push expected D and latency,
// completed results pop and compare; covers reset, extremes, zero, backpressure and abort.
`timescale 1ns/1ps
module tb_fp_to_tc_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;
  logic        busy;

  typedef struct {
    logic [11:0] d;
    int          lat;
  } exp_t;

  exp_t   sb_q[$];
  int     total_cnt;
  int     bad_cnt;
  longint accept_time;

  fp_to_tc_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
    int v;
    v = int'(f) * (1 << e);
    if (s) v = -v;
    return v[11:0];
  endfunction

  // Offers a word at a negedge, waits for in_ready, and records the accept edge.
  task automatic send_word(input logic s, input logic [2:0] e, input logic [3:0] f);
    exp_t x;
    int   n;
    @(negedge clk);
    S = s; E = e; F = f; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!in_ready) begin
      bad_cnt++;
      $display("[TB] FAIL accept_timeout got in_ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    accept_time = $time;
    x.d   = model(s, e, f);
    x.lat = int'(e) + 2;
    sb_q.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks D and latency, stalls, then completes the handshake.
  task automatic collect(input int stall, input logic pulse_in_valid);
    exp_t        x;
    int          n;
    int          lat;
    logic [11:0] held;
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    total_cnt++;
    if (!out_valid) begin
      bad_cnt++;
      $display("[TB] FAIL out_valid_timeout got out_valid=%0b want 1", out_valid);
      return;
    end
    if (sb_q.size() == 0) begin
      total_cnt++;
      bad_cnt++;
      $display("[TB] FAIL scoreboard_empty got size=0 want >0");
      return;
    end
    x   = sb_q.pop_front();
    lat = int'(($time - accept_time - 5) / 10);
    total_cnt++;
    if (D !== x.d) begin
      bad_cnt++;
      $display("[TB] FAIL result_D got %h want %h", D, x.d);
    end
    total_cnt++;
    if (lat !== x.lat) begin
      bad_cnt++;
      $display("[TB] FAIL latency got %0d want %0d", lat, x.lat);
    end
    held = D;
    for (int i = 0; i < stall; i++) begin
      if (pulse_in_valid) begin
        in_valid = i[0];
        S = 1'b0; E = 3'd1; F = 4'h3;
      end
      @(negedge clk);
      total_cnt++;
      if (D !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad_cnt++;
        $display("[TB] FAIL stall_hold got D=%h ov=%0b ir=%0b want D=%h ov=1 ir=0",
                 D, out_valid, in_ready, held);
      end
    end
    if (pulse_in_valid) in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== held) begin
      bad_cnt++;
      $display("[TB] FAIL handshake_release got ov=%0b ir=%0b D=%h want ov=0 ir=1 D=%h",
               out_valid, in_ready, D, held);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (D !== 12'h000 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++;
      $display("[TB] FAIL reset_state got D=%h ir=%0b ov=%0b busy=%0b want 000 1 0 0",
               D, in_ready, out_valid, busy);
    end
  endtask

  task automatic test_positive();
    send_word(1'b0, 3'd3, 4'hB);
    collect(0, 1'b0);
  endtask

  task automatic test_extremes();
    send_word(1'b0, 3'd7, 4'hF);
    collect(0, 1'b0);
    send_word(1'b1, 3'd7, 4'hF);
    collect(0, 1'b0);
  endtask

  task automatic test_zero();
    send_word(1'b1, 3'd4, 4'h0);
    collect(0, 1'b0);
    send_word(1'b0, 3'd0, 4'h1);
    collect(0, 1'b0);
  endtask

  // in_valid stays high through the DONE handshake; in_ready afterwards proves no accept in DONE.
  task automatic test_backpressure();
    send_word(1'b1, 3'd0, 4'h8);
    collect(6, 1'b1);
    send_word(1'b0, 3'd1, 4'h3);
    collect(0, 1'b0);
  endtask

  task automatic test_input_stability();
    send_word(1'b0, 3'd6, 4'h5);
    S = 1'b1; E = 3'd2; F = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total_cnt++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        bad_cnt++;
        $display("[TB] FAIL busy_during_shift got ir=%0b busy=%0b want 0 1", in_ready, busy);
      end
    end
    in_valid = 1'b0;
    collect(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      send_word(i[0], 3'(i + 1), 4'(9 + i));
      collect(0, 1'b0);
    end
  endtask

  task automatic test_abort();
    int seen;
    send_word(1'b1, 3'd5, 4'h9);
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || D === 12'h000) begin
      bad_cnt++;
      $display("[TB] FAIL pre_abort got busy=%0b D=%h want busy=1 D!=000", busy, D);
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (D !== 12'h000 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++;
      $display("[TB] FAIL async_abort got D=%h ir=%0b ov=%0b busy=%0b want 000 1 0 0",
               D, in_ready, out_valid, busy);
    end
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total_cnt++;
    if (seen !== 0 || D !== 12'h000) begin
      bad_cnt++;
      $display("[TB] FAIL post_abort got ov_cycles=%0d D=%h want 0 000", seen, D);
    end
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    S = 1'b0; E = '0; F = '0;
    test_reset();
    test_positive();
    test_extremes();
    test_zero();
    test_backpressure();
    test_input_stability();
    test_back_to_back();
    test_abort();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
